// File: rtl/exe_req_queue.sv
// exe_req_queue
// In-order request buffer between register-read and the ALU/divide execution
// unit. Holds up to DEPTH micro-ops in a circular buffer and issues the oldest
// one only when the execution unit advertises its functional unit. Waiting
// entries track branch resolution (mask bits cleared) and are killed by a
// mispredict on one of their branches or by a pipeline flush. Killed entries
// keep their slot and drain silently from the head, one bubble each.
//
// Ports
//   clock, reset                    clock; synchronous active-high reset
//   io_enq_valid / io_enq_ready     request handshake from register-read
//   io_enq_bits_fu_code/br_mask/payload   incoming request fields
//   io_fu_types                     FUs accepted this cycle (bit0 ALU, bit4 DIV)
//   io_deq_valid                    head entry issues this cycle
//   io_deq_bits_fu_code/br_mask/payload   head entry fields
//   io_brupdate_b1_resolve_mask     branches resolved this cycle
//   io_brupdate_b1_mispredict_mask  branches mispredicted this cycle
//   io_flush                        kill all held and incoming requests
//   io_count                        occupied entries, including dead ones
module exe_req_queue #(
  parameter int DEPTH     = 2,
  parameter int PAYLOAD_W = 256
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       io_enq_valid,
  output logic                       io_enq_ready,
  input  logic [9:0]                 io_enq_bits_fu_code,
  input  logic [19:0]                io_enq_bits_br_mask,
  input  logic [PAYLOAD_W-1:0]       io_enq_bits_payload,
  input  logic [9:0]                 io_fu_types,
  output logic                       io_deq_valid,
  output logic [9:0]                 io_deq_bits_fu_code,
  output logic [19:0]                io_deq_bits_br_mask,
  output logic [PAYLOAD_W-1:0]       io_deq_bits_payload,
  input  logic [19:0]                io_brupdate_b1_resolve_mask,
  input  logic [19:0]                io_brupdate_b1_mispredict_mask,
  input  logic                       io_flush,
  output logic [$clog2(DEPTH):0]     io_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic                 live_r    [DEPTH];
  logic [9:0]           fu_r      [DEPTH];
  logic [19:0]          mask_r    [DEPTH];
  logic [PAYLOAD_W-1:0] payload_r [DEPTH];
  logic [PW-1:0]        head_r;
  logic [PW-1:0]        tail_r;
  logic [CW-1:0]        count_r;

  logic [DEPTH-1:0]     kill_s;
  logic                 enq_fire_s;
  logic                 enq_live_s;
  logic                 head_kill_s;
  logic                 head_fu_ok_s;
  logic                 deq_fire_s;
  logic                 pop_s;

  // Per-entry kill: a flush or a mispredict on any branch in the entry's mask.
  always_comb begin
    kill_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      kill_s[i] = io_flush | (|(mask_r[i] & io_brupdate_b1_mispredict_mask));
    end
  end

  // Enqueue handshake; ready looks only at the registered count, so a pop in
  // the same cycle never frees a slot for the incoming request.
  always_comb begin
    io_enq_ready = (count_r < CW'(DEPTH));
    enq_fire_s   = io_enq_valid & io_enq_ready & ~reset;
    enq_live_s   = ~io_flush & ~(|(io_enq_bits_br_mask & io_brupdate_b1_mispredict_mask));
  end

  // Head decision: issue a live head whose FU is free, stall a live head whose
  // FU is busy, and silently drop a dead or just-killed head.
  always_comb begin
    head_kill_s  = kill_s[head_r];
    head_fu_ok_s = |(fu_r[head_r] & io_fu_types);
    deq_fire_s   = 1'b0;
    pop_s        = 1'b0;
    if (!reset && (count_r != {CW{1'b0}})) begin
      deq_fire_s = live_r[head_r] & ~head_kill_s & head_fu_ok_s;
      pop_s      = deq_fire_s | ~live_r[head_r] | head_kill_s;
    end else begin
      deq_fire_s = 1'b0;
      pop_s      = 1'b0;
    end
  end

  // Head-slot view for the execution unit; the mask already excludes branches
  // resolving this cycle.
  always_comb begin
    io_deq_valid        = deq_fire_s;
    io_deq_bits_fu_code = fu_r[head_r];
    io_deq_bits_br_mask = mask_r[head_r] & ~io_brupdate_b1_resolve_mask;
    io_deq_bits_payload = payload_r[head_r];
    io_count            = count_r;
  end

  // Pointers, occupancy and per-entry live flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        live_r[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (enq_fire_s && (tail_r == PW'(i))) begin
          live_r[i] <= enq_live_s;
        end else if (live_r[i] && kill_s[i]) begin
          live_r[i] <= 1'b0;
        end else begin
          live_r[i] <= live_r[i];
        end
      end
      if (enq_fire_s) begin
        tail_r <= tail_r + {{(PW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        head_r <= head_r + {{(PW-1){1'b0}}, 1'b1};
      end
      count_r <= count_r + CW'(enq_fire_s) - CW'(pop_s);
    end
  end

  // Entry contents; only slots under the live flag matter, so no reset here.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (enq_fire_s && (tail_r == PW'(i))) begin
        fu_r[i]      <= io_enq_bits_fu_code;
        mask_r[i]    <= io_enq_bits_br_mask & ~io_brupdate_b1_resolve_mask;
        payload_r[i] <= io_enq_bits_payload;
      end else if (live_r[i]) begin
        mask_r[i]    <= mask_r[i] & ~io_brupdate_b1_resolve_mask;
      end else begin
        mask_r[i]    <= mask_r[i];
      end
    end
  end

endmodule

// File: tb/tb_exe_req_queue.sv
// Self-checking bench for exe_req_queue (DEPTH = 2): directed scenarios with
// literal expectations plus a randomized phase, all compared every cycle
// against a queue-based reference model.
module tb_exe_req_queue;

  localparam int DEPTH = 2;
  localparam int PW    = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic          enq_valid;
  logic          enq_ready;
  logic [9:0]    enq_fu;
  logic [19:0]   enq_mask;
  logic [PW-1:0] enq_pl;
  logic [9:0]    fu_types;
  logic          deq_valid;
  logic [9:0]    deq_fu;
  logic [19:0]   deq_mask;
  logic [PW-1:0] deq_pl;
  logic [19:0]   res;
  logic [19:0]   mis;
  logic          flush;
  logic [1:0]    count;

  exe_req_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
    .clock                          (clk),
    .reset                          (reset),
    .io_enq_valid                   (enq_valid),
    .io_enq_ready                   (enq_ready),
    .io_enq_bits_fu_code            (enq_fu),
    .io_enq_bits_br_mask            (enq_mask),
    .io_enq_bits_payload            (enq_pl),
    .io_fu_types                    (fu_types),
    .io_deq_valid                   (deq_valid),
    .io_deq_bits_fu_code            (deq_fu),
    .io_deq_bits_br_mask            (deq_mask),
    .io_deq_bits_payload            (deq_pl),
    .io_brupdate_b1_resolve_mask    (res),
    .io_brupdate_b1_mispredict_mask (mis),
    .io_flush                       (flush),
    .io_count                       (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          live;
    logic [9:0]    fu;
    logic [19:0]   mask;
    logic [PW-1:0] pl;
  } ent_t;

  ent_t q[$];

  int checks   = 0;
  int failures = 0;
  int n_deq    = 0;
  int max_cnt  = 0;
  logic [19:0] last_deq_mask;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] rand_pl();
    logic [PW-1:0] v;
    for (int i = 0; i < PW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Model outputs for the current inputs, compared against the DUT.
  task automatic compare();
    int   n;
    logic exp_valid;
    logic kill;
    n = q.size();
    exp_valid = 1'b0;
    if (n > 0 && !reset) begin
      kill = flush || (|(q[0].mask & mis));
      exp_valid = q[0].live && !kill && (|(q[0].fu & fu_types));
    end
    check("count", PW'(count), PW'(n));
    check("enq_ready", PW'(enq_ready), PW'(n < DEPTH));
    check("deq_valid", PW'(deq_valid), PW'(exp_valid));
    if (n > 0) begin
      check("deq_fu", PW'(deq_fu), PW'(q[0].fu));
      check("deq_mask", PW'(deq_mask), PW'(q[0].mask & ~res));
      check("deq_payload", deq_pl, q[0].pl);
    end
    if (deq_valid === 1'b1) begin
      n_deq++;
      last_deq_mask = deq_mask;
    end
    if (int'(count) > max_cnt) max_cnt = int'(count);
  endtask

  // Advance the model across a rising edge using the inputs held this cycle.
  task automatic update();
    int   n;
    logic pop;
    ent_t e;
    if (reset) begin
      q.delete();
      return;
    end
    n = q.size();
    pop = 1'b0;
    if (n > 0) begin
      pop = !q[0].live || flush || (|(q[0].mask & mis)) || (|(q[0].fu & fu_types));
    end
    for (int i = 0; i < n; i++) begin
      e = q[i];
      if (e.live) begin
        if (flush || (|(e.mask & mis))) e.live = 1'b0;
        e.mask = e.mask & ~res;
      end
      q[i] = e;
    end
    if (pop) void'(q.pop_front());
    if (enq_valid && n < DEPTH) begin
      e.live = !flush && !(|(enq_mask & mis));
      e.fu   = enq_fu;
      e.mask = enq_mask & ~res;
      e.pl   = enq_pl;
      q.push_back(e);
    end
  endtask

  task automatic step_check();
    @(negedge clk);
    compare();
  endtask

  task automatic step_edge();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic tick();
    step_check();
    step_edge();
  endtask

  task automatic set_idle();
    reset = 1'b0; enq_valid = 1'b0; res = 20'h0; mis = 20'h0; flush = 1'b0;
  endtask

  task automatic enq(input logic [9:0] fu, input logic [19:0] m);
    enq_valid = 1'b1; enq_fu = fu; enq_mask = m; enq_pl = rand_pl();
  endtask

  initial begin
    set_idle();
    enq_fu = 10'h0; enq_mask = 20'h0; enq_pl = '0; fu_types = 10'h011;
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    q.delete();
    set_idle();

    // Reset state
    step_check();
    check("reset_count", PW'(count), PW'(0));
    check("reset_ready", PW'(enq_ready), PW'(1));
    step_edge();

    // ALU stream
    n_deq = 0; max_cnt = 0; fu_types = 10'h011;
    for (int i = 0; i < 4; i++) begin
      enq(10'h001, 20'h0);
      tick();
    end
    set_idle();
    tick();
    check("alu_issues", PW'(n_deq), PW'(4));
    check("alu_maxcount", PW'(max_cnt), PW'(1));

    // Divider stall and full
    n_deq = 0; fu_types = 10'h001;
    enq(10'h010, 20'h0); tick();
    enq(10'h001, 20'h0); tick();
    enq(10'h001, 20'h0); tick(); tick();
    step_check();
    check("stall_count", PW'(count), PW'(2));
    check("stall_ready", PW'(enq_ready), PW'(0));
    check("stall_no_issue", PW'(n_deq), PW'(0));
    step_edge();
    set_idle(); fu_types = 10'h011;
    step_check();
    check("div_first", PW'({deq_valid, deq_fu}), PW'({1'b1, 10'h010}));
    step_edge();
    step_check();
    check("alu_second", PW'({deq_valid, deq_fu}), PW'({1'b1, 10'h001}));
    step_edge();

    // Resolve
    fu_types = 10'h001;
    enq(10'h010, 20'h00006); tick();
    set_idle(); res = 20'h00002;
    step_check();
    check("resolve_same", PW'(deq_mask), PW'(20'h00004));
    step_edge();
    res = 20'h0;
    for (int i = 0; i < 2; i++) begin
      step_check();
      check("resolve_later", PW'(deq_mask), PW'(20'h00004));
      step_edge();
    end
    fu_types = 10'h011;
    step_check();
    check("resolve_issue", PW'({deq_valid, deq_mask}), PW'({1'b1, 20'h00004}));
    step_edge();

    // Mispredict
    n_deq = 0; fu_types = 10'h001;
    enq(10'h010, 20'h00001); tick();
    enq(10'h001, 20'h00001); mis = 20'h00001; tick();
    mis = 20'h0; enq(10'h001, 20'h00002); tick();
    set_idle(); tick(); tick();
    check("mispred_issues", PW'(n_deq), PW'(1));
    check("mispred_survivor", PW'(last_deq_mask), PW'(20'h00002));

    // Flush while full
    n_deq = 0; fu_types = 10'h001;
    enq(10'h010, 20'h0); tick();
    enq(10'h010, 20'h0); tick();
    enq(10'h001, 20'h0); flush = 1'b1;
    step_check();
    check("flush_blocked", PW'(enq_ready), PW'(0));
    step_edge();
    set_idle(); fu_types = 10'h011;
    tick(); tick();
    step_check();
    check("flush_drained", PW'({count, enq_ready}), PW'({2'd0, 1'b1}));
    check("flush_no_issue", PW'(n_deq), PW'(0));
    step_edge();

    // Reset mid-operation, then wrap
    fu_types = 10'h001;
    enq(10'h010, 20'h0); tick();
    enq(10'h010, 20'h0); tick();
    reset = 1'b1; fu_types = 10'h011; enq(10'h001, 20'h0);
    step_check();
    check("reset_no_issue", PW'(deq_valid), PW'(0));
    step_edge();
    set_idle();
    step_check();
    check("post_reset_count", PW'(count), PW'(0));
    step_edge();
    n_deq = 0;
    for (int i = 0; i < 10; i++) begin
      enq(10'h001, 20'h0);
      tick();
    end
    set_idle();
    tick();
    check("wrap_issues", PW'(n_deq), PW'(10));

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      set_idle();
      if ($urandom_range(0, 2) != 0) begin
        case ($urandom_range(0, 3))
          0:       enq(10'h001, 20'h1 << $urandom_range(0, 19));
          1:       enq(10'h010, 20'h1 << $urandom_range(0, 19));
          2:       enq(10'h001 << $urandom_range(0, 9), 20'($urandom) & 20'($urandom));
          default: enq(10'h001, 20'h0);
        endcase
      end
      fu_types = ($urandom_range(0, 1) == 0) ? 10'h011 : 10'($urandom);
      if ($urandom_range(0, 3) == 0)   res   = 20'h1 << $urandom_range(0, 19);
      if ($urandom_range(0, 7) == 0)   mis   = 20'h1 << $urandom_range(0, 19);
      if ($urandom_range(0, 99) == 0)  flush = 1'b1;
      if ($urandom_range(0, 299) == 0) reset = 1'b1;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
